// File: rtl/toggle_counter_pkg.sv
// Shared definitions for the toggle counter: direction constants, the
// next-count source selector and the modulo step helper.
package toggle_counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef enum logic [2:0] {
      CLR,
      LD,
      INC,
      DEC,
      HOLD
   } next_sel_t;

   // Modulo step in 32-bit arithmetic, wider than any practical WIDTH+1,
   // so a modulus of 2^WIDTH wraps without overflow before truncation.
   function automatic int unsigned wrap_next(input int unsigned count,
                                             input logic        up,
                                             input int unsigned modulus);
      int unsigned res;
      if (up == DIR_UP) begin
         res = (count == modulus - 1) ? 0 : count + 1;
      end else begin
         res = (count == 0) ? modulus - 1 : count - 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/step_edge_sync.sv
// Two-flop synchronizer plus previous-value flop for an asynchronous enable
// level; emits a one-cycle step per rising edge of the synchronized level.
// Only built with TOGGLE_COUNTER_STEP_EDGE_EN defined.
`ifdef TOGGLE_COUNTER_STEP_EDGE_EN
module step_edge_sync (
   input  logic clk,
   input  logic a_reset,
   input  logic en,
   output logic step
);

   logic sync1;
   logic sync2;
   logic sync3;

   // Synchronizer chain and edge-detect history, cleared by the async reset.
   always_ff @(posedge clk or negedge a_reset) begin
      if (!a_reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= en;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign step = sync2 & ~sync3;

endmodule
`endif

// File: rtl/toggle_counter_ctrl.sv
// Modulo-N up/down counter producing per-bit toggle enables (count ^ next)
// for a downstream TFF bank, with clear, saturating load and a registered
// terminal-count pulse. Optional macro TOGGLE_COUNTER_STEP_EDGE_EN turns
// `en` into an asynchronous level counted once per rising edge.
module toggle_counter_ctrl
   import toggle_counter_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 10
) (
   input  logic             clk,
   input  logic             a_reset,
   input  logic             en,
   input  logic             up,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] t_vec,
   output logic             tc
);

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic             step;
   logic             wrap;
   logic [WIDTH-1:0] load_sat;
   logic [WIDTH-1:0] next_count;
   next_sel_t        next_sel;

`ifdef TOGGLE_COUNTER_STEP_EDGE_EN
   step_edge_sync u_step_edge_sync (
      .clk     (clk),
      .a_reset (a_reset),
      .en      (en),
      .step    (step)
   );
`else
   assign step = en;
`endif

   // Compare one bit wider than WIDTH so MODULUS = 2^WIDTH never saturates.
   assign load_sat = ({1'b0, load_val} >= MOD_EXT) ? MAX_CNT : load_val;

   // Source of the next count, highest priority first.
   always_comb begin
      next_sel = HOLD;
      if (clear) begin
         next_sel = CLR;
      end else if (load) begin
         next_sel = LD;
      end else if (step) begin
         next_sel = (up == DIR_UP) ? INC : DEC;
      end
   end

   // Next count value and wrap detection; only counting steps can wrap.
   always_comb begin
      next_count = count;
      wrap       = 1'b0;
      unique case (next_sel)
         CLR: next_count = '0;
         LD:  next_count = load_sat;
         INC: begin
            next_count = WIDTH'(wrap_next(32'(count), DIR_UP, MODULUS));
            wrap       = (count == MAX_CNT);
         end
         DEC: begin
            next_count = WIDTH'(wrap_next(32'(count), DIR_DOWN, MODULUS));
            wrap       = (count == '0);
         end
         default: next_count = count;
      endcase
   end

   // Toggle enables are forced to zero while reset holds the TFF bank.
   assign t_vec = a_reset ? (count ^ next_count) : '0;

   // Count and terminal-count registers.
   always_ff @(posedge clk or negedge a_reset) begin
      if (!a_reset) begin
         count <= '0;
         tc    <= 1'b0;
      end else begin
         count <= next_count;
         tc    <= wrap;
      end
   end

endmodule

// File: tb/tb_toggle_counter_ctrl.sv
// Self-checking bench for toggle_counter_ctrl (WIDTH=4, MODULUS=10, default
// build). Expected values come from a modulo-arithmetic reference model.
module tb_toggle_counter_ctrl;

   localparam int W = 4;
   localparam int M = 10;

   logic         clk = 1'b0;
   logic         a_reset;
   logic         en;
   logic         up;
   logic         clear;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] count;
   logic [W-1:0] t_vec;
   logic         tc;

   int passed = 0;
   int total  = 0;

   int           m_count = 0;
   bit           m_tc    = 1'b0;
   logic [W-1:0] exp_tvec;
   logic [W-1:0] obs_tvec;
   logic [W-1:0] tff;

   toggle_counter_ctrl #(.WIDTH(W), .MODULUS(M)) dut (
      .clk      (clk),
      .a_reset  (a_reset),
      .en       (en),
      .up       (up),
      .clear    (clear),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .t_vec    (t_vec),
      .tc       (tc)
   );

   always #5 clk = ~clk;

   // Downstream TFF bank driven only by t_vec.
   always_ff @(posedge clk or negedge a_reset) begin
      if (!a_reset) tff <= '0;
      else          tff <= tff ^ t_vec;
   end

   // Drive one cycle (entered at posedge+1), update the model, sample t_vec
   // before the edge and leave at the following posedge+1.
   task automatic step_cycle(input bit c, input bit l, input logic [W-1:0] lv,
                             input bit e, input bit u);
      int nxt;
      bit wr;
      clear    = c;
      load     = l;
      load_val = lv;
      en       = e;
      up       = u;
      wr       = 1'b0;
      if (c) nxt = 0;
      else if (l) nxt = (int'(lv) >= M) ? M - 1 : int'(lv);
      else if (e) begin
         if (u) begin
            nxt = (m_count + 1) % M;
            wr  = (m_count == M - 1);
         end else begin
            nxt = (m_count + M - 1) % M;
            wr  = (m_count == 0);
         end
      end else nxt = m_count;
      exp_tvec = W'(m_count ^ nxt);
      #1;
      obs_tvec = t_vec;
      @(posedge clk);
      #1;
      m_count = nxt;
      m_tc    = wr;
   endtask

   task automatic test_reset;
      a_reset = 1'b0; en = 1'b1; up = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
      total++; if (tc !== 1'b0) $display("FAIL reset_tc: got %0b want 0", tc); else passed++;
      total++; if (t_vec !== 4'd0) $display("FAIL reset_tvec: got %b want 0000", t_vec); else passed++;
      a_reset = 1'b1;
      m_count = 0; m_tc = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         step_cycle(0, 0, 4'd0, 1, 1);
         total++; if (count !== W'(m_count)) $display("FAIL run10_count[%0d]: got %0d want %0d", i, count, m_count); else passed++;
         total++; if (tc !== m_tc) $display("FAIL run10_tc[%0d]: got %0b want %0b", i, tc, m_tc); else passed++;
      end
      total++; if (count !== 4'd0 || tc !== 1'b1) $display("FAIL run10_end: got count=%0d tc=%0b want 0/1", count, tc); else passed++;
      step_cycle(0, 0, 4'd0, 0, 1);
      total++; if (tc !== 1'b0) $display("FAIL run10_tc_one_cycle: got %0b want 0", tc); else passed++;
      total++; if (obs_tvec !== 4'd0) $display("FAIL hold_tvec: got %b want 0000", obs_tvec); else passed++;
   endtask

   task automatic test_up_wrap;
      step_cycle(0, 1, 4'd9, 0, 1);
      total++; if (count !== 4'd9) $display("FAIL upwrap_load: got %0d want 9", count); else passed++;
      step_cycle(0, 0, 4'd0, 1, 1);
      total++; if (obs_tvec !== 4'b1001) $display("FAIL upwrap_tvec: got %b want 1001", obs_tvec); else passed++;
      total++; if (count !== 4'd0 || tc !== 1'b1) $display("FAIL upwrap: got count=%0d tc=%0b want 0/1", count, tc); else passed++;
      step_cycle(0, 0, 4'd0, 0, 1);
      total++; if (tc !== 1'b0) $display("FAIL upwrap_tc_once: got %0b want 0", tc); else passed++;
   endtask

   task automatic test_down_wrap;
      step_cycle(0, 0, 4'd0, 1, 0);
      total++; if (obs_tvec !== 4'b1001) $display("FAIL dnwrap_tvec: got %b want 1001", obs_tvec); else passed++;
      total++; if (count !== 4'd9 || tc !== 1'b1) $display("FAIL dnwrap: got count=%0d tc=%0b want 9/1", count, tc); else passed++;
      step_cycle(0, 0, 4'd0, 1, 0);
      total++; if (count !== 4'd8 || tc !== 1'b0) $display("FAIL dnwrap_next: got count=%0d tc=%0b want 8/0", count, tc); else passed++;
   endtask

   task automatic test_priority;
      step_cycle(1, 1, 4'd5, 1, 1);
      total++; if (obs_tvec !== 4'b1000) $display("FAIL prio_tvec: got %b want 1000", obs_tvec); else passed++;
      total++; if (count !== 4'd0) $display("FAIL prio_clear: got %0d want 0", count); else passed++;
      step_cycle(0, 1, 4'd14, 1, 1);
      total++; if (count !== 4'd9 || tc !== 1'b0) $display("FAIL load_sat: got count=%0d tc=%0b want 9/0", count, tc); else passed++;
      step_cycle(0, 1, 4'd15, 1, 0);
      total++; if (obs_tvec !== 4'd0) $display("FAIL load_sat_same_tvec: got %b want 0000", obs_tvec); else passed++;
      total++; if (count !== 4'd9 || tc !== 1'b0) $display("FAIL load_sat15: got count=%0d tc=%0b want 9/0", count, tc); else passed++;
      step_cycle(1, 0, 4'd0, 0, 0);
      total++; if (count !== 4'd0 || tc !== 1'b0) $display("FAIL clear_no_tc: got count=%0d tc=%0b want 0/0", count, tc); else passed++;
   endtask

   task automatic test_async_reset;
      step_cycle(0, 1, 4'd6, 0, 1);
      #3;
      a_reset = 1'b0;
      #1;
      total++; if (count !== 4'd0 || tc !== 1'b0) $display("FAIL async_reset: got count=%0d tc=%0b want 0/0", count, tc); else passed++;
      en = 1'b0;
      @(posedge clk);
      #3;
      a_reset = 1'b1;
      m_count = 0; m_tc = 1'b0;
      step_cycle(0, 0, 4'd0, 1, 1);
      total++; if (count !== 4'd1) $display("FAIL first_step_after_release: got %0d want 1", count); else passed++;
   endtask

   task automatic test_tff_random;
      int errs = 0;
      for (int i = 0; i < 200; i++) begin
         step_cycle($urandom_range(15) == 0, $urandom_range(7) == 0, W'($urandom_range(15)),
                    $urandom_range(3) != 0, $urandom_range(1) == 1);
         total++; if (obs_tvec !== exp_tvec) begin $display("FAIL rnd_tvec[%0d]: got %b want %b", i, obs_tvec, exp_tvec); errs++; end else passed++;
         total++; if (count !== W'(m_count)) begin $display("FAIL rnd_count[%0d]: got %0d want %0d", i, count, m_count); errs++; end else passed++;
         total++; if (tc !== m_tc) begin $display("FAIL rnd_tc[%0d]: got %0b want %0b", i, tc, m_tc); errs++; end else passed++;
         total++; if (tff !== W'(m_count)) begin $display("FAIL rnd_tff[%0d]: got %0d want %0d", i, tff, m_count); errs++; end else passed++;
         if (errs > 20) break;
      end
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_priority();
      test_async_reset();
      test_tff_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
